// File: rtl/axis_uart_bram_master.sv
// Host-side UART BRAM protocol initiator: parallel requests to AXI-Stream command frames.
// Define AXIS_UART_BRAM_MASTER_TIMEOUT_EN to enable the read-response timeout.
module axis_uart_bram_master #(
    parameter int unsigned BYTE_NUM       = 4,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MEM_WIDTH      = BYTE_NUM * BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [BYTE_NUM-1:0]   req_be_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [MEM_WIDTH-1:0]  req_data_i,
    output logic                  rsp_valid_o,
    output logic [MEM_WIDTH-1:0]  rsp_data_o,
    output logic                  rsp_err_o,
    output logic [7:0]            m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    input  logic [7:0]            s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o
);

    localparam int unsigned AddrBytes = ADDR_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle, StSendOp, StSendAddr, StSendBe, StSendData, StWaitRsp, StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [BYTE_NUM-1:0]   be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  data_q, data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [MEM_WIDTH-1:0]  rx_q, rx_d;
    logic [MEM_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                  tx_hs;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic [MEM_WIDTH-1:0]  data_sh;
    logic [7:0]            be_byte;

`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;
    assign rsp_err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign rsp_err_o      = 1'b0;
`endif

    // RX side never stalls: stray bytes outside a read response are simply dropped
    assign s_axis_tready_o = 1'b1;
    assign req_ready_o     = (state_q == StIdle);
    assign rsp_valid_o     = (state_q == StDone);
    assign rsp_data_o      = rsp_data_q;
    assign tx_hs           = m_axis_tvalid_o && m_axis_tready_i;

    always_comb begin
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = 8'h00;
        addr_sh         = addr_q >> (int'(cnt_q) * BYTE_WIDTH);
        data_sh         = data_q >> (int'(cnt_q) * BYTE_WIDTH);
        be_byte         = '0;
        be_byte[BYTE_NUM-1:0] = be_q;
        unique case (state_q)
            StSendOp: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = wr_q ? 8'h01 : 8'h02;
            end
            StSendAddr: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = addr_sh[7:0];
            end
            StSendBe: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = be_byte;
            end
            StSendData: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = data_sh[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        be_d       = be_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        rsp_data_d = rsp_data_q;
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
        timer_d    = timer_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StSendOp;
                    wr_d    = req_wr_i;
                    be_d    = req_be_i;
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    cnt_d   = '0;
                    rx_d    = '0;
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StSendOp: begin
                if (tx_hs) begin
                    state_d = StSendAddr;
                    cnt_d   = '0;
                end
            end
            StSendAddr: begin
                if (tx_hs) begin
                    if (cnt_q == 8'(AddrBytes - 1)) begin
                        cnt_d   = '0;
                        state_d = wr_q ? StSendBe : StWaitRsp;
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StSendBe: begin
                if (tx_hs) begin
                    state_d = StSendData;
                    cnt_d   = '0;
                end
            end
            StSendData: begin
                if (tx_hs) begin
                    if (cnt_q == 8'(BYTE_NUM - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StWaitRsp: begin
                if (s_axis_tvalid_i) begin
                    for (int unsigned i = 0; i < BYTE_NUM; i++) begin
                        if (cnt_q == 8'(i)) rx_d[i*BYTE_WIDTH +: 8] = s_axis_tdata_i;
                    end
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (cnt_q == 8'(BYTE_NUM - 1)) begin
                        state_d    = StDone;
                        rsp_data_d = rx_d;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
                else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Partial response: received bytes kept, missing slots stay zero
                    state_d    = StDone;
                    rsp_data_d = rx_q;
                    err_d      = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
`endif
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rx_q       <= '0;
            rsp_data_q <= '0;
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
            timer_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            rsp_data_q <= rsp_data_d;
`ifdef AXIS_UART_BRAM_MASTER_TIMEOUT_EN
            timer_q    <= timer_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: doc/axis_uart_bram_master.md
# axis_uart_bram_master

Host-side initiator for the UART BRAM access protocol: converts parallel memory read/write requests into UART command frames on an AXI-Stream byte output and reassembles read-response bytes from an AXI-Stream byte input. It sits between a local controller (CPU, test sequencer) and a pair of AXI-Stream UART TX/RX cores whose far end is the UART BRAM controller. One request is in flight at a time.

## Interface
- BYTE_NUM, 4, bytes per memory word
- BYTE_WIDTH, 8, bits per byte; only 8 supported
- ADDR_WIDTH, 32, address width; multiple of 8
- TIMEOUT_CYCLES, 1000000, max idle cycles between response bytes (timeout build only)
- MEM_WIDTH, BYTE_NUM*BYTE_WIDTH, word width
---
- clk_i  in  1  clock; single clock domain
- arstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_wr_i  in  1  1 = write, 0 = read
- req_be_i  in  BYTE_NUM  write byte enables
- req_addr_i  in  ADDR_WIDTH  word address
- req_data_i  in  MEM_WIDTH  write data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  MEM_WIDTH  read data (held until next completion)
- rsp_err_o  out  1  timeout flag, valid with rsp_valid_o
- m_axis_tdata_o  out  8  TX byte to UART TX
- m_axis_tvalid_o  out  1  TX byte valid
- m_axis_tready_i  in  1  UART TX ready
- s_axis_tdata_i  in  8  RX byte from UART RX
- s_axis_tvalid_i  in  1  RX byte valid
- s_axis_tready_o  out  1  RX ready

## Operation
- Frame format, all multi-byte fields LSB first:
  - write: opcode 0x01, ADDR_WIDTH/8 address bytes, 1 byte-enable byte (bit i = req_be_i[i], upper bits 0), BYTE_NUM data bytes
  - read: opcode 0x02, ADDR_WIDTH/8 address bytes; response is BYTE_NUM data bytes LSB first
- Request fields registered on acceptance; inputs may change afterwards.
- FSM: IDLE -> SEND_OP -> SEND_ADDR -> (wr) SEND_BE -> SEND_DATA -> DONE; (rd) SEND_ADDR -> WAIT_RSP -> DONE; DONE -> IDLE.
- Byte counter advances only on m_axis_tvalid_o && m_axis_tready_i; tdata stable while tvalid high and not accepted.
- WAIT_RSP: each accepted RX byte is written into byte slot [cnt] of the response register; after byte BYTE_NUM-1 -> DONE.
- Writes get no response bytes; completion is the last TX byte handshake, rsp_err_o = 0, rsp_data_o unchanged.
- s_axis_tready_o = 1 in every state; bytes arriving outside WAIT_RSP are accepted and discarded (flush of stray/late bytes).
- Reset mid-frame: all state and outputs return to reset values immediately; partial frame abandoned (far end resyncs by its own means).

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, s_axis_tready_o=1.
- req_ready_o=1 only in IDLE; cycle after acceptance: m_axis_tvalid_o=1 with opcode.
- Back-to-back TX with tready held high: one byte per cycle; write frame for defaults = 10 bytes, read frame = 5 bytes.
- rsp_valid_o pulses in the cycle after the final TX handshake (write) or final RX handshake (read); FSM back in IDLE, req_ready_o=1, the cycle after that.
- Minimum write latency, acceptance to rsp_valid_o, defaults and tready=1: 11 cycles.

## Configuration
- AXIS_UART_BRAM_MASTER_TIMEOUT_EN defined: counter in WAIT_RSP clears on entry and on every RX byte; on reaching TIMEOUT_CYCLES-1 with no byte, go DONE with rsp_err_o=1, rsp_data_o holding received bytes and zeros in missing slots.
- Not defined: no counter; WAIT_RSP waits indefinitely; rsp_err_o tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Write addr 0x00000010, data 0xDEADBEEF, be 4'b1111, tready=1 -> TX bytes 01 10 00 00 00 0F EF BE AD DE, rsp_valid 11 cycles after acceptance, err=0.
- Read addr 0x00000004, respond 78 56 34 12 -> TX 02 04 00 00 00, rsp_data=0x12345678, err=0.
- Write with random tready backpressure -> identical byte sequence, tdata stable while stalled, no duplicated/dropped bytes.
- Stray RX bytes 0xAA during IDLE/SEND phases, then valid read response -> stray bytes discarded, rsp_data from response only.
- Timeout build, TIMEOUT_CYCLES=100, read answered with 2 bytes 0x11 0x22 then silence -> rsp_valid with err=1, rsp_data=0x00002211; non-timeout build never completes.
- arstn_i asserted during byte 3 of a write -> all outputs at reset values same cycle; new read after release frames correctly.
